// File: rtl/lc_host_pkg.sv
// Shared types for the MCSE lifecycle host requester.
// State enum, status encodings and default response bit positions.
package lc_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_AUTH,
    ST_GAP,
    ST_DONE
  } lc_state_e;

  localparam logic [1:0] LC_ST_NONE    = 2'b00;
  localparam logic [1:0] LC_ST_PASS    = 2'b01;
  localparam logic [1:0] LC_ST_FAIL    = 2'b10;
  localparam logic [1:0] LC_ST_TIMEOUT = 2'b11;

  localparam int LC_ACK_BIT  = 0;
  localparam int LC_PASS_BIT = 1;
  localparam int LC_FAIL_BIT = 2;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lc_phase_timer.sv
// Per-phase cycle counter, cleared on state entry.
// Flags expiry at LIMIT-1 and holds there instead of wrapping.
module lc_phase_timer
  import lc_host_pkg::*;
#(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expired
);

  localparam int W = cnt_w(LIMIT);

  logic [W-1:0] cnt_q;

  assign expired = (cnt_q == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/lc_host_requester.sv
// Host-side requester for the MCSE lifecycle transition handshake.
// Define LC_RESP_SYNC_EN to pass resp through a 2-flop synchronizer.
module lc_host_requester
  import lc_host_pkg::*;
#(
  parameter int ID_W      = 256,
  parameter int RESP_W    = 32,
  parameter int ACK_BIT   = LC_ACK_BIT,
  parameter int PASS_BIT  = LC_PASS_BIT,
  parameter int FAIL_BIT  = LC_FAIL_BIT,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ID_W-1:0]   cmd_transition_id,
  input  logic [ID_W-1:0]   cmd_auth_id,
  output logic [ID_W-1:0]   lc_transition_id,
  output logic              lc_transition_request_in,
  output logic [ID_W-1:0]   lc_authentication_id,
  output logic              lc_authentication_valid,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [1:0]        retries
);

  localparam int RW =
    (MAX_RETRY > 3) ? $clog2(MAX_RETRY + 1) : 2;

  lc_state_e   state_q, state_d;
  logic [1:0]  status_q, status_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [ID_W-1:0] tid_q, aid_q;
  logic        accept, expired, ent;
  logic [2:0]  rb, rs;
  logic        resp_unused;

  assign resp_unused = ^resp;
  assign rb = {resp[FAIL_BIT], resp[PASS_BIT], resp[ACK_BIT]};

`ifdef LC_RESP_SYNC_EN
  logic [2:0] s1_q, s2_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= rb;
      s2_q <= s1_q;
    end
  end
  assign rs = s2_q;
`else
  assign rs = rb;
`endif

  assign accept = cmd_valid && (state_q == ST_IDLE);
  // Restart the phase count whenever a state is entered.
  assign ent = (state_d != state_q) || (state_q == ST_IDLE);

  lc_phase_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (ent),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    retry_d  = retry_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d  = ST_REQ;
          status_d = LC_ST_NONE;
          retry_d  = '0;
        end
      end
      ST_REQ: begin
        if (rs[0]) state_d = ST_AUTH;
        else if (expired) state_d = ST_GAP;
      end
      ST_AUTH: begin
        if (rs[2]) begin
          status_d = LC_ST_FAIL;
          state_d  = ST_DONE;
        end else if (rs[1]) begin
          status_d = LC_ST_PASS;
          state_d  = ST_DONE;
        end else if (expired) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = ST_REQ;
        end else begin
          status_d = LC_ST_TIMEOUT;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      status_q <= LC_ST_NONE;
      retry_q  <= '0;
      tid_q    <= '0;
      aid_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      retry_q  <= retry_d;
      if (accept) begin
        tid_q <= cmd_transition_id;
        aid_q <= cmd_auth_id;
      end
    end
  end

  generate
    if (RW > 2) begin : g_sat
      assign retries = (retry_q > RW'(3)) ?
        2'd3 : retry_q[1:0];
    end else begin : g_nosat
      assign retries = retry_q[1:0];
    end
  endgenerate

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign status    = status_q;

  assign lc_transition_id         = tid_q;
  assign lc_authentication_id     = aid_q;
  assign lc_transition_request_in = (state_q == ST_REQ);
  assign lc_authentication_valid  = (state_q == ST_AUTH);

endmodule
